// File: rtl/noc_local_depacketizer.sv
// noc_local_depacketizer: receive end of a NoC local port. It checks the header and tail marks, the destination and the length, strips header and tail, and streams the payload with a last flag and the source ID.
// Latency: a data word is visible on out_valid one cycle after the next data or tail flit is accepted (staging register followed by a first-word-fall-through FIFO).
// Backpressure: receive_ready is low while the payload FIFO is full or reset is asserted. Output words hold while out_valid & !out_ready.
// Optional: define NOC_DEPKT_STATS_EN to add the stat_pkt_cnt and stat_err_cnt outputs.
module noc_local_depacketizer #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_X_WIDTH = 4,
  parameter int unsigned ID_Y_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned X_ID       = 0,
  parameter int unsigned Y_ID       = 0,
  parameter logic [7:0]  HEAD_MARK  = 8'hA5,
  parameter logic [7:0]  TAIL_MARK  = 8'h5A,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [ID_X_WIDTH-1:0] out_src_x,
  output logic [ID_Y_WIDTH-1:0] out_src_y,
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic                  pkt_done
`ifdef NOC_DEPKT_STATS_EN
  ,
  output logic [15:0]           stat_pkt_cnt,
  output logic [15:0]           stat_err_cnt
`endif
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1 + ID_X_WIDTH + ID_Y_WIDTH;
  // Field positions, packed downward from the mark byte.
  localparam int unsigned SX_LSB  = DATA_WIDTH - 8 - ID_X_WIDTH;
  localparam int unsigned SY_LSB  = SX_LSB - ID_Y_WIDTH;
  localparam int unsigned DX_LSB  = SY_LSB - ID_X_WIDTH;
  localparam int unsigned DY_LSB  = DX_LSB - ID_Y_WIDTH;
  localparam int unsigned LN_LSB  = DY_LSB - LEN_WIDTH;

  localparam logic [ID_X_WIDTH-1:0] OWN_X   = ID_X_WIDTH'(X_ID);
  localparam logic [ID_Y_WIDTH-1:0] OWN_Y   = ID_Y_WIDTH'(Y_ID);
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] ERR_HEAD_MARK = 3'd1;
  localparam logic [2:0] ERR_DEST      = 3'd2;
  localparam logic [2:0] ERR_TAIL_MARK = 3'd3;
  localparam logic [2:0] ERR_LENGTH    = 3'd4;
  localparam logic [2:0] ERR_NO_TAIL   = 3'd5;
  localparam logic [2:0] ERR_ORPHAN    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

  state_t                state_q, state_d;
  logic [ID_X_WIDTH-1:0] src_x_q, src_x_d;
  logic [ID_Y_WIDTH-1:0] src_y_q, src_y_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  stg_vld_q, stg_vld_d;
  logic [DATA_WIDTH-1:0] stg_dat_q, stg_dat_d;
  logic                  err_vld_q, err_vld_d;
  logic [2:0]            err_code_q, err_code_d;
  logic                  pkt_done_q, pkt_done_d;

  logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [ENTRY_W-1:0]    head_entry;

  logic                  flit_acc;
  logic                  take_hdr;
  logic                  push;
  logic                  push_last;
  logic                  pop;

  logic [7:0]            flit_mark;
  logic [ID_X_WIDTH-1:0] flit_sx, flit_dx;
  logic [ID_Y_WIDTH-1:0] flit_sy, flit_dy;
  logic [LEN_WIDTH-1:0]  flit_len;

  assign flit_mark = receive_flit[DATA_WIDTH-1 -: 8];
  assign flit_sx   = receive_flit[SX_LSB +: ID_X_WIDTH];
  assign flit_sy   = receive_flit[SY_LSB +: ID_Y_WIDTH];
  assign flit_dx   = receive_flit[DX_LSB +: ID_X_WIDTH];
  assign flit_dy   = receive_flit[DY_LSB +: ID_Y_WIDTH];
  assign flit_len  = receive_flit[LN_LSB +: LEN_WIDTH];

  assign receive_ready = !noc_rst && (count_q < DEPTH_C);
  assign flit_acc      = receive_valid && receive_ready;

  // Packet decode: header checks, staging of data flits, and last-marking of the staged word on tail or early header.
  always_comb begin
    state_d    = state_q;
    src_x_d    = src_x_q;
    src_y_d    = src_y_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    stg_vld_d  = stg_vld_q;
    stg_dat_d  = stg_dat_q;
    err_vld_d  = 1'b0;
    err_code_d = 3'd0;
    pkt_done_d = 1'b0;
    push       = 1'b0;
    push_last  = 1'b0;
    take_hdr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flit_acc) begin
          if (receive_is_header) begin
            take_hdr = 1'b1;
          end else begin
            err_vld_d  = 1'b1;
            err_code_d = ERR_ORPHAN;
          end
        end
      end
      S_BODY: begin
        if (flit_acc) begin
          if (receive_is_header) begin
            // The previous packet never saw its tail: close it out and decode the new header now.
            err_vld_d  = 1'b1;
            err_code_d = ERR_NO_TAIL;
            push       = stg_vld_q;
            push_last  = 1'b1;
            stg_vld_d  = 1'b0;
            take_hdr   = 1'b1;
          end else if (receive_is_tail) begin
            push       = stg_vld_q;
            push_last  = 1'b1;
            stg_vld_d  = 1'b0;
            pkt_done_d = 1'b1;
            state_d    = S_IDLE;
            if (flit_mark != TAIL_MARK) begin
              err_vld_d  = 1'b1;
              err_code_d = ERR_TAIL_MARK;
            end else if (cnt_q != len_q) begin
              err_vld_d  = 1'b1;
              err_code_d = ERR_LENGTH;
            end
          end else begin
            push      = stg_vld_q;
            push_last = 1'b0;
            stg_dat_d = receive_flit;
            stg_vld_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      S_DROP: begin
        if (flit_acc && receive_is_tail && !receive_is_header) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Header decode is shared by IDLE and the early-header case in BODY; an earlier error code in this cycle wins.
    if (take_hdr) begin
      if (flit_mark != HEAD_MARK) begin
        state_d = S_DROP;
        if (!err_vld_d) begin
          err_vld_d  = 1'b1;
          err_code_d = ERR_HEAD_MARK;
        end
      end else if ((flit_dx != OWN_X) || (flit_dy != OWN_Y)) begin
        state_d = S_DROP;
        if (!err_vld_d) begin
          err_vld_d  = 1'b1;
          err_code_d = ERR_DEST;
        end
      end else begin
        state_d = S_BODY;
        src_x_d = flit_sx;
        src_y_d = flit_sy;
        len_d   = flit_len;
        cnt_d   = '0;
      end
    end
  end

  // Decoder state, staging register and the registered error/done pulses.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q    <= S_IDLE;
      src_x_q    <= '0;
      src_y_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_dat_q  <= '0;
      err_vld_q  <= 1'b0;
      err_code_q <= 3'd0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      stg_vld_q  <= stg_vld_d;
      stg_dat_q  <= stg_dat_d;
      err_vld_q  <= err_vld_d;
      err_code_q <= err_code_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign err_valid = err_vld_q;
  assign err_code  = err_code_q;
  assign pkt_done  = pkt_done_q;

  // Payload FIFO storage. A push needs an accepted flit, and an accepted flit needs free space.
  always_ff @(posedge noc_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {stg_dat_q, push_last, src_x_q, src_y_q};
    end
  end

  assign pop = out_valid && out_ready;

  // FIFO pointers and occupancy.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // The head entry is shown directly. The outputs are forced to zero while the FIFO is empty so that they read as zero after reset.
  assign out_valid  = (count_q != '0);
  assign head_entry = fifo_mem[rd_ptr_q];
  assign out_data   = out_valid ? head_entry[ENTRY_W-1 -: DATA_WIDTH] : '0;
  assign out_last   = out_valid ? head_entry[ID_X_WIDTH+ID_Y_WIDTH] : 1'b0;
  assign out_src_x  = out_valid ? head_entry[ID_Y_WIDTH +: ID_X_WIDTH] : '0;
  assign out_src_y  = out_valid ? head_entry[0 +: ID_Y_WIDTH] : '0;

`ifdef NOC_DEPKT_STATS_EN
  logic [15:0] stat_pkt_q;
  logic [15:0] stat_err_q;

  // Free-running event counters that wrap at 16 bits.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      stat_pkt_q <= '0;
      stat_err_q <= '0;
    end else begin
      if (pkt_done_q) begin
        stat_pkt_q <= stat_pkt_q + 16'd1;
      end
      if (err_vld_q) begin
        stat_err_q <= stat_err_q + 16'd1;
      end
    end
  end

  assign stat_pkt_cnt = stat_pkt_q;
  assign stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_noc_local_depacketizer.sv
// Testbench for noc_local_depacketizer, built with X_ID=2 and Y_ID=1.
// It uses table-driven packet cases, hand-written corner sequences and randomized traffic checked against a packet-level model.
// Output words, error codes and pkt_done pulses are compared in order against the model's expected streams.
module tb_noc_local_depacketizer;

  logic        noc_clk = 1'b0;
  logic        noc_rst;
  logic        receive_valid;
  logic        receive_ready;
  logic [63:0] receive_flit;
  logic        receive_is_header;
  logic        receive_is_tail;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic [3:0]  out_src_x;
  logic [3:0]  out_src_y;
  logic        err_valid;
  logic [2:0]  err_code;
  logic        pkt_done;
`ifdef NOC_DEPKT_STATS_EN
  logic [15:0] stat_pkt_cnt;
  logic [15:0] stat_err_cnt;
`endif

  always #5 noc_clk = ~noc_clk;

  noc_local_depacketizer #(
    .DATA_WIDTH(64), .ID_X_WIDTH(4), .ID_Y_WIDTH(4), .LEN_WIDTH(8),
    .X_ID(2), .Y_ID(1), .HEAD_MARK(8'hA5), .TAIL_MARK(8'h5A), .FIFO_DEPTH(8)
  ) dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst),
    .receive_valid(receive_valid), .receive_ready(receive_ready),
    .receive_flit(receive_flit), .receive_is_header(receive_is_header),
    .receive_is_tail(receive_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src_x(out_src_x), .out_src_y(out_src_y),
    .err_valid(err_valid), .err_code(err_code), .pkt_done(pkt_done)
`ifdef NOC_DEPKT_STATS_EN
    , .stat_pkt_cnt(stat_pkt_cnt), .stat_err_cnt(stat_err_cnt)
`endif
  );

  typedef struct packed {
    logic [63:0] d;
    logic        last;
    logic [3:0]  sx;
    logic [3:0]  sy;
  } word_t;

  typedef struct {
    logic [7:0] hmark;
    logic [3:0] dx;
    logic [3:0] dy;
    int         len;
    int         ndata;
    logic [7:0] tmark;
    int         exp_err;    // 0 = no error expected
    int         exp_pkt;
    int         exp_words;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Observed streams. The monitor only appends to them; the test keeps read indices.
  word_t got_w[$];
  int    got_e[$];
  int    got_pkts = 0;
  int    gw_rd = 0, ge_rd = 0, pk_rd = 0;

  // Expected streams produced by the model.
  word_t exp_w[$];
  int    exp_e[$];
  int    exp_pkts = 0;
  int    m_tot_pkts = 0, m_tot_errs = 0;

  // Packet-level model state.
  bit         m_body, m_drop, m_pend;
  word_t      m_pw;
  logic [3:0] m_sx, m_sy;
  int         m_len, m_cnt;

  bit rnd_rdy = 1'b0;
  bit rdy_fix = 1'b1;

  always @(posedge noc_clk) begin
    #2;
    out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_fix;
  end

  always @(negedge noc_clk) begin
    if (out_valid && out_ready) got_w.push_back({out_data, out_last, out_src_x, out_src_y});
    if (err_valid) got_e.push_back(int'(err_code));
    if (pkt_done) got_pkts++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mkf(input logic [7:0] mark, input logic [3:0] sx, input logic [3:0] sy,
                                      input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] len);
    mkf = {mark, sx, sy, dx, dy, len, 32'h0BAD_F00D};
  endfunction

  task automatic push_err(input int code);
    exp_e.push_back(code);
    m_tot_errs++;
  endtask

  task automatic model_flush(input bit last);
    if (m_pend) begin
      m_pw.last = last;
      exp_w.push_back(m_pw);
      m_pend = 1'b0;
    end
  endtask

  task automatic model_hdr(input logic [63:0] f, input bit quiet);
    if (f[63:56] != 8'hA5) begin
      m_drop = 1'b1;
      if (!quiet) push_err(1);
    end else if (f[47:44] != 4'd2 || f[43:40] != 4'd1) begin
      m_drop = 1'b1;
      if (!quiet) push_err(2);
    end else begin
      m_body = 1'b1;
      m_sx = f[55:52];
      m_sy = f[51:48];
      m_len = int'(f[39:32]);
      m_cnt = 0;
    end
  endtask

  // Apply one accepted flit to the packet-level model.
  task automatic model_flit(input logic [63:0] f, input logic h, input logic t);
    if (m_drop) begin
      if (t && !h) m_drop = 1'b0;
    end else if (m_body) begin
      if (h) begin
        push_err(5);
        model_flush(1'b1);
        m_body = 1'b0;
        model_hdr(f, 1'b1);
      end else if (t) begin
        model_flush(1'b1);
        m_body = 1'b0;
        exp_pkts++;
        m_tot_pkts++;
        if (f[63:56] != 8'h5A) push_err(3);
        else if (m_cnt != m_len) push_err(4);
      end else begin
        model_flush(1'b0);
        m_pw.d = f;
        m_pw.sx = m_sx;
        m_pw.sy = m_sy;
        m_pw.last = 1'b0;
        m_pend = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end else if (h) begin
      model_hdr(f, 1'b0);
    end else begin
      push_err(6);
    end
  endtask

  // Called just after a clock edge. Holds the flit until it is accepted.
  task automatic send(input logic [63:0] f, input logic h, input logic t);
    int w;
    w = 0;
    receive_valid = 1'b1;
    receive_flit = f;
    receive_is_header = h;
    receive_is_tail = t;
    @(negedge noc_clk);
    while (!receive_ready && w < 2000) begin
      @(negedge noc_clk);
      w++;
    end
    if (!receive_ready) begin
      checks++;
      errors++;
      $display("FAIL send timeout: receive_ready got 0 expected 1");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
    end
    @(posedge noc_clk);
    #1;
    receive_valid = 1'b0;
    receive_is_header = 1'b0;
    receive_is_tail = 1'b0;
    model_flit(f, h, t);
  endtask

  // Wait until the DUT has been quiet for a few cycles, then return just after a clock edge.
  task automatic drain();
    int quiet;
    quiet = 0;
    for (int c = 0; c < 1000 && quiet < 4; c++) begin
      @(negedge noc_clk);
      if (out_valid || err_valid || pkt_done) quiet = 0;
      else quiet++;
    end
    if (quiet < 4) chk("drain timeout", 0, 1);
    @(posedge noc_clk);
    #1;
  endtask

  task automatic compare_streams(input string tag);
    int n;
    n = got_w.size() - gw_rd;
    chk({tag, " word count"}, n, exp_w.size());
    for (int i = 0; i < exp_w.size() && i < n; i++) chk({tag, " word"}, got_w[gw_rd + i], exp_w[i]);
    n = got_e.size() - ge_rd;
    chk({tag, " err count"}, n, exp_e.size());
    for (int i = 0; i < exp_e.size() && i < n; i++) chk({tag, " err code"}, got_e[ge_rd + i], exp_e[i]);
    chk({tag, " pkt_done count"}, got_pkts - pk_rd, exp_pkts);
    gw_rd = got_w.size();
    ge_rd = got_e.size();
    pk_rd = got_pkts;
    exp_w.delete();
    exp_e.delete();
    exp_pkts = 0;
  endtask

  // Called just after a clock edge. Holds reset for n edges and clears the model.
  task automatic do_reset(input int n);
    noc_rst = 1'b1;
    repeat (n) @(posedge noc_clk);
    #1;
    noc_rst = 1'b0;
    m_body = 1'b0;
    m_drop = 1'b0;
    m_pend = 1'b0;
    exp_w.delete();
    exp_e.delete();
    exp_pkts = 0;
    m_tot_pkts = 0;
    m_tot_errs = 0;
    gw_rd = got_w.size();
    ge_rd = got_e.size();
    pk_rd = got_pkts;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  vec_t tbl[8];
  int   e0, w0, p0, len, nd;
  logic [7:0] hm, tm;
  logic [3:0] dx;

  initial begin
    tbl[0] = '{8'hA5, 4'd2, 4'd1, 2, 2, 8'h5A, 0, 1, 2};
    tbl[1] = '{8'hA5, 4'd1, 4'd1, 1, 1, 8'h5A, 2, 0, 0};
    tbl[2] = '{8'h00, 4'd2, 4'd1, 1, 1, 8'h5A, 1, 0, 0};
    tbl[3] = '{8'hA5, 4'd2, 4'd1, 3, 2, 8'h00, 3, 1, 2};
    tbl[4] = '{8'hA5, 4'd2, 4'd1, 3, 2, 8'h5A, 4, 1, 2};
    tbl[5] = '{8'hA5, 4'd2, 4'd1, 0, 0, 8'h5A, 0, 1, 0};
    tbl[6] = '{8'hA5, 4'd2, 4'd1, 1, 0, 8'h5A, 4, 1, 0};
    tbl[7] = '{8'hA5, 4'd2, 4'd1, 2, 3, 8'h33, 3, 1, 3};

    noc_rst = 1'b1;
    receive_valid = 1'b0;
    receive_flit = '0;
    receive_is_header = 1'b0;
    receive_is_tail = 1'b0;
    @(negedge noc_clk);
    chk("ready in reset", receive_ready, 0);
    @(posedge noc_clk);
    #1;
    do_reset(2);
    @(negedge noc_clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_last", out_last, 0);
    chk("rst out_src", {out_src_x, out_src_y}, 0);
    chk("rst err_valid", err_valid, 0);
    chk("rst err_code", err_code, 0);
    chk("rst pkt_done", pkt_done, 0);
    chk("ready after reset", receive_ready, 1);
`ifdef NOC_DEPKT_STATS_EN
    chk("rst stat_pkt_cnt", stat_pkt_cnt, 0);
    chk("rst stat_err_cnt", stat_err_cnt, 0);
`endif
    @(posedge noc_clk);
    #1;

    // Table of single packets: header, ndata data flits, tail.
    foreach (tbl[k]) begin
      e0 = got_e.size();
      w0 = got_w.size();
      p0 = got_pkts;
      send(mkf(tbl[k].hmark, 4'd3, 4'd0, tbl[k].dx, tbl[k].dy, 8'(tbl[k].len)), 1'b1, 1'b0);
      for (int j = 0; j < tbl[k].ndata; j++) send(64'(j + 1) * 64'h11, 1'b0, 1'b0);
      send(mkf(tbl[k].tmark, 4'd3, 4'd0, 4'd2, 4'd1, 8'(tbl[k].len)), 1'b0, 1'b1);
      drain();
      chk("tbl err pulses", got_e.size() - e0, (tbl[k].exp_err != 0));
      if (tbl[k].exp_err != 0 && got_e.size() > e0) chk("tbl err code", got_e[e0], tbl[k].exp_err);
      chk("tbl pkt_done", got_pkts - p0, tbl[k].exp_pkt);
      chk("tbl words", got_w.size() - w0, tbl[k].exp_words);
      if (tbl[k].exp_words > 0 && got_w.size() == w0 + tbl[k].exp_words) begin
        chk("tbl first data", got_w[w0].d, 64'h11);
        chk("tbl src", {got_w[w0].sx, got_w[w0].sy}, 8'h30);
        chk("tbl final last", got_w[w0 + tbl[k].exp_words - 1].last, 1);
      end
      compare_streams("tbl");
    end

    // Backpressure: 10 data flits with the output stalled.
    rdy_fix = 1'b0;
    w0 = got_w.size();
    send(mkf(8'hA5, 4'd4, 4'd5, 4'd2, 4'd1, 8'd10), 1'b1, 1'b0);
    for (int j = 0; j < 8; j++) send(64'hB000 + 64'(j), 1'b0, 1'b0);
    @(negedge noc_clk);
    chk("bp ready after 8 data", receive_ready, 1);
    @(posedge noc_clk);
    #1;
    send(64'hB008, 1'b0, 1'b0);
    repeat (3) @(negedge noc_clk);
    chk("bp ready after 9 data", receive_ready, 0);
    chk("bp head held", out_data, 64'hB000);
    @(posedge noc_clk);
    #1;
    rdy_fix = 1'b1;
    send(64'hB009, 1'b0, 1'b0);
    send(mkf(8'h5A, 4'd4, 4'd5, 4'd2, 4'd1, 8'd10), 1'b0, 1'b1);
    drain();
    chk("bp words", got_w.size() - w0, 10);
    if (got_w.size() == w0 + 10) begin
      chk("bp word9 last", got_w[w0 + 8].last, 0);
      chk("bp word10 last", got_w[w0 + 9].last, 1);
      chk("bp word10 data", got_w[w0 + 9].d, 64'hB009);
    end
    compare_streams("bp");

    // Header arriving in the middle of a body, then an orphan data flit.
    e0 = got_e.size();
    w0 = got_w.size();
    send(mkf(8'hA5, 4'd3, 4'd0, 4'd2, 4'd1, 8'd1), 1'b1, 1'b0);
    send(64'hAA, 1'b0, 1'b0);
    send(mkf(8'hA5, 4'd5, 4'd6, 4'd2, 4'd1, 8'd1), 1'b1, 1'b0);
    send(64'hBB, 1'b0, 1'b0);
    send(mkf(8'h5A, 4'd5, 4'd6, 4'd2, 4'd1, 8'd1), 1'b0, 1'b1);
    send(64'hCC, 1'b0, 1'b0);
    drain();
    if (got_e.size() >= e0 + 2) begin
      chk("early hdr err5", got_e[e0], 5);
      chk("orphan err6", got_e[e0 + 1], 6);
    end else chk("early hdr err pulses", got_e.size() - e0, 2);
    if (got_w.size() >= w0 + 2) begin
      chk("early hdr AA", {got_w[w0].d, got_w[w0].last}, {64'hAA, 1'b1});
      chk("second pkt BB src", {got_w[w0 + 1].d, got_w[w0 + 1].sx, got_w[w0 + 1].sy}, {64'hBB, 8'h56});
    end
    compare_streams("early hdr");

    // Reset in the middle of a body with three words buffered.
    rdy_fix = 1'b0;
    send(mkf(8'hA5, 4'd7, 4'd7, 4'd2, 4'd1, 8'd5), 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) send(64'hC0 + 64'(j), 1'b0, 1'b0);
    @(negedge noc_clk);
    chk("pre-reset out_valid", out_valid, 1);
    @(posedge noc_clk);
    #1;
    do_reset(1);
    @(negedge noc_clk);
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset ready", receive_ready, 1);
`ifdef NOC_DEPKT_STATS_EN
    chk("mid reset stat_pkt_cnt", stat_pkt_cnt, 0);
    chk("mid reset stat_err_cnt", stat_err_cnt, 0);
`endif
    @(posedge noc_clk);
    #1;
    rdy_fix = 1'b1;
    send(mkf(8'hA5, 4'd1, 4'd2, 4'd2, 4'd1, 8'd2), 1'b1, 1'b0);
    send(64'hD1, 1'b0, 1'b0);
    send(64'hD2, 1'b0, 1'b0);
    send(mkf(8'h5A, 4'd1, 4'd2, 4'd2, 4'd1, 8'd2), 1'b0, 1'b1);
    drain();
    compare_streams("post reset");

    // Randomized traffic with random output stalls.
    rnd_rdy = 1'b1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(0, 5);
      nd = ($urandom_range(0, 9) < 7) ? len : $urandom_range(0, 6);
      hm = ($urandom_range(0, 9) == 0) ? 8'h3C : 8'hA5;
      dx = ($urandom_range(0, 9) == 0) ? 4'd7 : 4'd2;
      tm = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'h5A;
      if ($urandom_range(0, 15) == 0) send({$urandom, $urandom}, 1'b0, 1'b0);
      send(mkf(hm, 4'($urandom), 4'($urandom), dx, 4'd1, 8'(len)), 1'b1, 1'b0);
      for (int j = 0; j < nd; j++) begin
        send({$urandom, $urandom}, 1'b0, 1'b0);
        repeat ($urandom_range(0, 2)) begin
          @(posedge noc_clk);
          #1;
        end
      end
      if ($urandom_range(0, 9) != 0) send(mkf(tm, 4'd0, 4'd0, 4'd2, 4'd1, 8'(len)), 1'b0, 1'b1);
    end
    send(mkf(8'h5A, 4'd0, 4'd0, 4'd2, 4'd1, 8'd0), 1'b0, 1'b1);
    drain();
    rnd_rdy = 1'b0;
    compare_streams("random");
`ifdef NOC_DEPKT_STATS_EN
    chk("stat_pkt_cnt", stat_pkt_cnt, 16'(m_tot_pkts));
    chk("stat_err_cnt", stat_err_cnt, 16'(m_tot_errs));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/noc_local_depacketizer.md
Name: noc_local_depacketizer

Overview:
- Terminal receive end of a NoC local port. Accepts header/data/tail flits from the router's local output using the valid/ready, is_header and is_tail handshake.
- Validates the header and tail markers, the destination ID and the payload length.
- Strips the header and tail. Buffers payload flits in a FIFO and presents them as a stream with a last marker and per-word source ID.
- Reports protocol errors as one-cycle pulses. Counterpart to the packet-generating test/traffic nodes.

Parameters:
- DATA_WIDTH, 64, flit width in bits.
- ID_X_WIDTH, 4, X ID width.
- ID_Y_WIDTH, 4, Y ID width.
- LEN_WIDTH, 8, header length field width (number of data flits).
- X_ID, 0, own X coordinate.
- Y_ID, 0, own Y coordinate.
- HEAD_MARK, 8'hA5, marker in header flit bits [DATA_WIDTH-1 -: 8].
- TAIL_MARK, 8'h5A, marker in tail flit bits [DATA_WIDTH-1 -: 8].
- FIFO_DEPTH, 8, payload FIFO entries (power of two, >=2).

Ports:
- noc_clk  in  1  clock.
- noc_rst  in  1  synchronous active-high reset.
- receive_valid  in  1  flit valid.
- receive_ready  out  1  flit accepted when valid&ready.
- receive_flit  in  DATA_WIDTH  flit.
- receive_is_header  in  1  header flit.
- receive_is_tail  in  1  tail flit.
- out_valid  out  1  payload word valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_WIDTH  payload word.
- out_last  out  1  final payload word of packet.
- out_src_x  out  ID_X_WIDTH  source X of word.
- out_src_y  out  ID_Y_WIDTH  source Y of word.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  error code, valid with err_valid.
- pkt_done  out  1  one-cycle pulse on accepted tail of a non-dropped packet.

Behaviour:
- Clock and reset: one clock, noc_clk. Reset noc_rst is synchronous and active-high.
- Reset values: state=IDLE, FIFO empty, staging register empty, out_valid=0, out_last=0, out_data=0, out_src_x=0, out_src_y=0, err_valid=0, err_code=0, pkt_done=0.
  - receive_ready=0 while noc_rst=1, then 1.
  - Reset mid-packet discards all buffered data.
- Header layout, MSB down: mark[8], src_x, src_y, dst_x, dst_y, len[LEN_WIDTH]; remaining bits ignored. Tail uses the same layout with TAIL_MARK.
- Flow control: receive_ready = (fifo_count < FIFO_DEPTH). A flit transfers on receive_valid & receive_ready. One flit per cycle, so at most one error per cycle.
- Staging register: holds the most recent data flit so that out_last can be applied when the tail arrives.
  - A new data flit while staging is full pushes the old staged word (last=0) and captures the new one.
- States:
  - IDLE:
    - Header with mark==HEAD_MARK and dst==(X_ID,Y_ID): latch src and len, clear data counter, go to BODY.
    - Header with bad mark: err 1, go to DROP.
    - Header with wrong destination: err 2, go to DROP.
    - Non-header flit: err 6 (orphan), discard, stay in IDLE.
  - BODY:
    - Data flit: stage it, counter+1 (saturating at 2^LEN_WIDTH-1).
    - Tail flit: push staged word with last=1 (if any), pulse pkt_done, go to IDLE.
      - Tail mark != TAIL_MARK: err 3.
      - Counter != len: err 4.
      - If both apply, err 3 takes priority.
      - Data is delivered regardless of err 3 or err 4.
    - Header flit: err 5. Push staged word with last=1, then process the new header exactly as in IDLE, in the same cycle.
    - A flit with both is_header and is_tail is treated as a header.
  - DROP: accept and discard flits until a tail is accepted, then go to IDLE. No pkt_done, no further errors.
- Zero-payload packet (header then tail): nothing is pushed, pkt_done pulses, err 4 only if len != 0.
- Output side: FIFO entry = {data, last, src_x, src_y}. Output is first-word-fall-through. out_* hold stable while out_valid & !out_ready.
- Simultaneous push and pop on a full FIFO: allowed only if receive_ready was 1. Count is unchanged.
- Latency: a data word appears on out_valid 1 cycle after the following data or tail flit is accepted.

Optional Feature:
- Macro: NOC_DEPKT_STATS_EN.
- Defined: adds outputs stat_pkt_cnt[15:0] and stat_err_cnt[15:0].
  - stat_pkt_cnt increments on pkt_done.
  - stat_err_cnt increments on err_valid.
  - Both wrap at 16'hFFFF->0 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- X_ID=2, Y_ID=1. Header(src 3,0; dst 2,1; len 2), data 64'h11, data 64'h22, tail, with out_ready=1.
  -> out 64'h11 last=0 then 64'h22 last=1, src 3/0, pkt_done pulse once, no err.
- Header with dst (1,1), data, tail.
  -> err_code 2 pulse on header, no out_valid, no pkt_done, state back to IDLE after tail.
- out_ready=0 with a 10-data-flit packet.
  -> receive_ready drops after 9 flits (8 FIFO entries plus staging). On releasing out_ready, all 10 words emerge in order, only the 10th has last=1.
- Header len=3, two data flits, tail with mark 8'h00.
  -> err_code 3, both words delivered (second with last=1), pkt_done pulses.
- Header, data 64'hAA, then a new valid header.
  -> err_code 5, 64'hAA emitted with last=1, second packet then decoded normally. A data flit sent in IDLE gives err_code 6.
- noc_rst asserted one cycle mid-BODY with 3 words buffered.
  -> out_valid=0 next cycle, FIFO empty. A following complete packet is decoded cleanly. With NOC_DEPKT_STATS_EN, the counters read 0 after reset.
